// File: rtl/icache_assoc_if.sv
// Request/response bundle between the fetch/fill front end and icache_assoc.
// Signal names match the original flat ports so existing connections map one-to-one.
interface icache_assoc_if #(
    parameter int unsigned pc_width_p      = 20,
    parameter int unsigned hit_way_width_p = 1
);
    logic                       v_i;
    logic                       w_i;
    logic                       flush_i;
    logic [pc_width_p-1:0]      w_pc_i;
    logic [31:0]                w_instr_i;
    logic [pc_width_p-1:0]      pc_i;
    logic [31:0]                instr_o;
    logic [pc_width_p-1:0]      pc_r_o;
    logic                       miss_o;
    logic [hit_way_width_p-1:0] hit_way_o;
    logic                       flush_r_o;

    modport master (
        output v_i, w_i, flush_i, w_pc_i, w_instr_i, pc_i,
        input  instr_o, pc_r_o, miss_o, hit_way_o, flush_r_o
    );

    modport slave (
        input  v_i, w_i, flush_i, w_pc_i, w_instr_i, pc_i,
        output instr_o, pc_r_o, miss_o, hit_way_o, flush_r_o
    );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: per-line valid bits, sequential word fills,
// round-robin replacement, one-cycle fetch latency with hit/miss and hit-way status.
module icache_assoc #(
    parameter int unsigned tag_width_p           = 12,
    parameter int unsigned sets_p                = 64,
    parameter int unsigned ways_p                = 2,
    parameter int unsigned block_size_in_words_p = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    icache_assoc_if.slave bus
);
    localparam int unsigned set_w_lp    = $clog2(sets_p);
    localparam int unsigned off_w_lp    = $clog2(block_size_in_words_p);
    localparam int unsigned pc_width_lp = tag_width_p + set_w_lp + off_w_lp;
    localparam int unsigned way_w_lp    = (ways_p > 1) ? $clog2(ways_p) : 1;
    localparam int unsigned line_w_lp   = 32 * block_size_in_words_p;
    localparam logic [off_w_lp-1:0] last_word_lp = off_w_lp'(block_size_in_words_p - 1);

    logic [tag_width_p-1:0] tag_r   [sets_p][ways_p];
    logic [ways_p-1:0]      valid_r [sets_p];
    logic [way_w_lp-1:0]    rr_r    [sets_p];
    logic [line_w_lp-1:0]   mem_r   [ways_p][sets_p];
    logic [line_w_lp-1:0]   rdata_r [ways_p];
    logic [31:0]            fill_buf_r [block_size_in_words_p-1];
    logic [off_w_lp-1:0]    write_count_r;
    logic [pc_width_lp-1:0] pc_r;
    logic                   flush_r;

    logic                   fetch, fill, commit;
    logic [tag_width_p-1:0] f_tag, r_tag;
    logic [set_w_lp-1:0]    f_set, r_set, q_set;
    logic [off_w_lp-1:0]    f_off, r_off;
    logic [line_w_lp-1:0]   fill_line;
    logic                   fill_hit, free_found, use_rr;
    logic [way_w_lp-1:0]    fill_hit_way, free_way, target_way;
    logic                   hit;
    logic [way_w_lp-1:0]    hit_way;

    assign fetch  = bus.v_i & ~bus.w_i;
    assign fill   = bus.v_i & bus.w_i;
    assign commit = fill & (write_count_r == last_word_lp);

    assign {f_tag, f_set, f_off} = bus.w_pc_i;
    assign {r_tag, r_set, r_off} = pc_r;
    assign q_set = bus.pc_i[off_w_lp +: set_w_lp];

    always_comb begin
        fill_line = '0;
        for (int unsigned i = 0; i < block_size_in_words_p - 1; i++)
            fill_line[32*i +: 32] = fill_buf_r[i];
        fill_line[32*(block_size_in_words_p-1) +: 32] = bus.w_instr_i;
    end

    // Victim choice: matching valid tag first, then lowest invalid way, then round-robin.
    always_comb begin
        fill_hit     = 1'b0;
        fill_hit_way = '0;
        free_found   = 1'b0;
        free_way     = '0;
        for (int unsigned w = 0; w < ways_p; w++) begin
            if (!fill_hit && valid_r[f_set][w] && (tag_r[f_set][w] == f_tag)) begin
                fill_hit     = 1'b1;
                fill_hit_way = way_w_lp'(w);
            end
            if (!free_found && !valid_r[f_set][w]) begin
                free_found = 1'b1;
                free_way   = way_w_lp'(w);
            end
        end
        use_rr     = !fill_hit && !free_found;
        target_way = fill_hit ? fill_hit_way : (free_found ? free_way : rr_r[f_set]);
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < ways_p; w++) begin
            if (!hit && valid_r[r_set][w] && (tag_r[r_set][w] == r_tag)) begin
                hit     = 1'b1;
                hit_way = way_w_lp'(w);
            end
        end
    end

    assign bus.instr_o   = rdata_r[hit_way][32*r_off +: 32];
    assign bus.miss_o    = ~hit;
    assign bus.hit_way_o = hit_way;
    assign bus.pc_r_o    = pc_r;
    assign bus.flush_r_o = flush_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_r          <= '0;
            flush_r       <= 1'b0;
            write_count_r <= '0;
            for (int unsigned s = 0; s < sets_p; s++) begin
                valid_r[s] <= '0;
                rr_r[s]    <= '0;
            end
        end else begin
            if (fetch)
                pc_r <= bus.pc_i;
            flush_r <= fetch ? 1'b0 : bus.flush_i;
            if (fill)
                write_count_r <= write_count_r + 1'b1;
            if (commit) begin
                valid_r[f_set][target_way] <= 1'b1;
                if (use_rr)
                    rr_r[f_set] <= (ways_p > 1) ? rr_r[f_set] + 1'b1 : '0;
            end
            // Flush is last so it overrides a coincident commit and a partial fill.
            if (bus.flush_i) begin
                write_count_r <= '0;
                for (int unsigned s = 0; s < sets_p; s++)
                    valid_r[s] <= '0;
            end
        end
    end

    // Data storage: single-port per way, read output holds between fetches.
    always_ff @(posedge clk_i) begin
        if (fill && !commit)
            fill_buf_r[write_count_r] <= bus.w_instr_i;
        if (commit) begin
            mem_r[target_way][f_set] <= fill_line;
            tag_r[f_set][target_way] <= f_tag;
        end
        if (fetch) begin
            for (int unsigned w = 0; w < ways_p; w++)
                rdata_r[w] <= mem_r[w][q_set];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && fill)
            assert (f_off == write_count_r)
            else $error("icache_assoc: fill offset %0d, expected %0d", f_off, write_count_r);
    end
endmodule
